// File: rtl/cam_pkg.sv
// Shared defaults and helpers for the CAM read-modify-write arbiter.
package cam_pkg;

  localparam int DEF_N_REQ      = 2;
  localparam int DEF_KEY_SIZE   = 16;
  localparam int DEF_VALUE_SIZE = 256;
  localparam int DEF_INFLIGHT   = 4;

  // A single requester still needs one bit to hold its ID in the FIFO.
  function automatic int id_width(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/cam_rmw_arbiter_if.sv
// Bus bundle for cam_rmw_arbiter: requester, table lookup/response, per-requester
// response and update channels. The slave modport is the arbiter's view.
interface cam_rmw_arbiter_if
  import cam_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int KEY_SIZE   = DEF_KEY_SIZE,
  parameter int VALUE_SIZE = DEF_VALUE_SIZE
);

  logic [N_REQ*KEY_SIZE-1:0]   s_req_index;
  logic [N_REQ-1:0]            s_req_valid;
  logic [N_REQ-1:0]            s_req_ready;

  logic [KEY_SIZE-1:0]         m_lookup_req_index;
  logic                        m_lookup_req_valid;
  logic                        m_lookup_req_ready;

  logic [VALUE_SIZE-1:0]       s_lookup_value_data;
  logic                        s_lookup_value_valid;
  logic                        s_lookup_value_ready;

  logic [N_REQ*VALUE_SIZE-1:0] m_value_data;
  logic [N_REQ-1:0]            m_value_valid;
  logic [N_REQ-1:0]            m_value_ready;

  logic [KEY_SIZE-1:0]         s_update_index;
  logic [VALUE_SIZE-1:0]       s_update_data;
  logic                        s_update_valid;
  logic                        s_update_ready;

  logic [KEY_SIZE-1:0]         m_update_index;
  logic [VALUE_SIZE-1:0]       m_update_data;
  logic                        m_update_valid;
  logic                        m_update_ready;

  logic                        err_unmatched;

  modport slave (
    input  s_req_index, s_req_valid, m_lookup_req_ready,
    input  s_lookup_value_data, s_lookup_value_valid, m_value_ready,
    input  s_update_index, s_update_data, s_update_valid, m_update_ready,
    output s_req_ready, m_lookup_req_index, m_lookup_req_valid,
    output s_lookup_value_ready, m_value_data, m_value_valid,
    output s_update_ready, m_update_index, m_update_data, m_update_valid,
    output err_unmatched
  );

  modport master (
    output s_req_index, s_req_valid, m_lookup_req_ready,
    output s_lookup_value_data, s_lookup_value_valid, m_value_ready,
    output s_update_index, s_update_data, s_update_valid, m_update_ready,
    input  s_req_ready, m_lookup_req_index, m_lookup_req_valid,
    input  s_lookup_value_ready, m_value_data, m_value_valid,
    input  s_update_ready, m_update_index, m_update_data, m_update_valid,
    input  err_unmatched
  );

endinterface

// File: rtl/cam_rmw_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter
  import cam_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  logic [ID_W:0]   cand_wide;
  logic [ID_W-1:0] cand;
  logic            found;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred; blocking '=' is right here.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand_wide   = '0;
    cand        = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand_wide = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (cand_wide >= (ID_W+1)'(N_REQ)) cand_wide = cand_wide - (ID_W+1)'(N_REQ);
      cand = cand_wide[ID_W-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/cam_rmw_arbiter.sv
// Lookup arbiter for read-modify-write on a shared table: blocks requests whose key
// is already in flight, routes responses back in order, retires keys on update.
module cam_rmw_arbiter
  import cam_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int KEY_SIZE   = DEF_KEY_SIZE,
  parameter int VALUE_SIZE = DEF_VALUE_SIZE,
  parameter int INFLIGHT   = DEF_INFLIGHT
) (
  input  logic               clk,
  input  logic               rst,
  cam_rmw_arbiter_if.slave   bus
);

  localparam int ID_W   = id_width(N_REQ);
  localparam int SLOT_W = $clog2(INFLIGHT);
  localparam int CNT_W  = SLOT_W + 1;

  logic [INFLIGHT-1:0] valid_q, valid_d;
  logic [KEY_SIZE-1:0] key_q  [INFLIGHT];
  logic [ID_W-1:0]     fifo_q [INFLIGHT];
  logic [SLOT_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;

  logic                tbl_full, fifo_full, fifo_empty;
  logic [N_REQ-1:0]    hit, eligible, grant, value_valid_vec;
  logic [ID_W-1:0]     grant_idx, head_id;
  logic                lookup_hs, value_hs, update_hs, head_ready;
  logic [SLOT_W-1:0]   alloc_slot, retire_slot;
  logic                alloc_found, retire_hit;
  logic [KEY_SIZE-1:0] sel_key;
  logic [VALUE_SIZE-1:0] value_data;

  // Hazard check looks only at registered keys, so a same-cycle grant never blocks.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_REQ; i++)
      for (int e = 0; e < INFLIGHT; e++)
        if (valid_q[e] && key_q[e] == bus.s_req_index[i*KEY_SIZE +: KEY_SIZE]) hit[i] = 1'b1;
  end

  assign tbl_full   = &valid_q;
  assign fifo_full  = (count_q == CNT_W'(INFLIGHT));
  assign fifo_empty = (count_q == '0);
  assign eligible   = bus.s_req_valid & ~hit & {N_REQ{~tbl_full & ~fifo_full}};

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    sel_key = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) sel_key = bus.s_req_index[i*KEY_SIZE +: KEY_SIZE];
  end

  assign bus.m_lookup_req_valid = |grant;
  assign bus.m_lookup_req_index = sel_key;
  assign bus.s_req_ready        = grant & {N_REQ{bus.m_lookup_req_ready}};
  assign lookup_hs              = bus.m_lookup_req_valid & bus.m_lookup_req_ready;

  // Responses come back in lookup order; the FIFO head names the owner.
  assign head_id = fifo_q[rd_ptr_q];

  always_comb begin
    head_ready      = 1'b0;
    value_valid_vec = '0;
    for (int i = 0; i < N_REQ; i++)
      if (head_id == ID_W'(i)) begin
        head_ready         = bus.m_value_ready[i];
        value_valid_vec[i] = bus.s_lookup_value_valid & ~fifo_empty;
      end
  end

  assign value_data               = bus.s_lookup_value_data;
  assign bus.m_value_data         = {N_REQ{value_data}};
  assign bus.m_value_valid        = value_valid_vec;
  assign bus.s_lookup_value_ready = ~fifo_empty & head_ready;
  assign value_hs                 = bus.s_lookup_value_valid & bus.s_lookup_value_ready;

  assign bus.m_update_index = bus.s_update_index;
  assign bus.m_update_data  = bus.s_update_data;
  assign bus.m_update_valid = bus.s_update_valid;
  assign bus.s_update_ready = bus.m_update_ready;
  assign update_hs          = bus.s_update_valid & bus.m_update_ready;
  assign bus.err_unmatched  = err_q;

  always_comb begin
    alloc_found = 1'b0;
    alloc_slot  = '0;
    retire_hit  = 1'b0;
    retire_slot = '0;
    for (int e = 0; e < INFLIGHT; e++) begin
      if (!alloc_found && !valid_q[e]) begin
        alloc_found = 1'b1;
        alloc_slot  = SLOT_W'(e);
      end
      if (!retire_hit && valid_q[e] && key_q[e] == bus.s_update_index) begin
        retire_hit  = 1'b1;
        retire_slot = SLOT_W'(e);
      end
    end
  end

  // Allocate and retire always touch different slots, so both may apply at once.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = 1'b0;
    if (update_hs) begin
      if (retire_hit) valid_d[retire_slot] = 1'b0;
      else            err_d = 1'b1;
    end
    if (lookup_hs) begin
      valid_d[alloc_slot] = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
    if (value_hs) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({lookup_hs, value_hs})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // NOTE: key and ID storage is not reset; valid bits and the FIFO count
  // decide whether a slot means anything, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (lookup_hs) begin
      key_q[alloc_slot] <= sel_key;
      fifo_q[wr_ptr_q]  <= grant_idx;
    end
  end

endmodule

// File: tb/tb_cam_rmw_arbiter.sv
// Directed bench for cam_rmw_arbiter with a queue-based reference model checked every cycle.
module tb_cam_rmw_arbiter;

  localparam int N   = 2;
  localparam int KW  = 16;
  localparam int VW  = 256;
  localparam int INF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_rmw_arbiter_if #(.N_REQ(N), .KEY_SIZE(KW), .VALUE_SIZE(VW)) bus ();

  cam_rmw_arbiter #(.N_REQ(N), .KEY_SIZE(KW), .VALUE_SIZE(VW), .INFLIGHT(INF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit model_on = 1'b0;

  // Reference model: set of in-flight keys, ordered owner IDs, last winner.
  logic [KW-1:0] tbl[$];
  int            ids[$];
  int            last_win = N - 1;
  bit            exp_err  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit in_table(input logic [KW-1:0] k);
    foreach (tbl[j]) if (tbl[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [KW-1:0] idx, input logic v);
    bus.s_req_index[i*KW +: KW] = idx;
    bus.s_req_valid[i]          = v;
  endtask

  task automatic set_upd(input logic v, input logic [KW-1:0] idx);
    bus.s_update_valid = v;
    bus.s_update_index = idx;
    bus.s_update_data  = {16{idx}};
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    logic [KW-1:0] k;
    bit            elig [N];
    int            win, head, c;
    logic [N-1:0]  exp_sr, exp_mvv;
    bit            exp_vr, found;
    forever begin
      @(negedge clk);
      if (model_on) begin
        for (int i = 0; i < N; i++) begin
          k       = bus.s_req_index[i*KW +: KW];
          elig[i] = bus.s_req_valid[i] && !in_table(k) && tbl.size() < INF && ids.size() < INF;
        end
        win = -1;
        for (int s = 1; s <= N; s++) begin
          c = (last_win + s) % N;
          if (win < 0 && elig[c]) win = c;
        end
        exp_sr = '0;
        if (win >= 0 && bus.m_lookup_req_ready) exp_sr[win] = 1'b1;
        check("m_s_req_ready", 64'(bus.s_req_ready), 64'(exp_sr));
        check("m_lookup_valid", 64'(bus.m_lookup_req_valid), 64'(win >= 0));
        if (win >= 0)
          check("m_lookup_index", 64'(bus.m_lookup_req_index), 64'(bus.s_req_index[win*KW +: KW]));

        head   = (ids.size() > 0) ? ids[0] : -1;
        exp_vr = (head >= 0) && bus.m_value_ready[head];
        exp_mvv = '0;
        if (head >= 0 && bus.s_lookup_value_valid) exp_mvv[head] = 1'b1;
        check("m_value_ready_up", 64'(bus.s_lookup_value_ready), 64'(exp_vr));
        check("m_value_valid", 64'(bus.m_value_valid), 64'(exp_mvv));
        check("m_value_bcast", 64'(bus.m_value_data == {N{bus.s_lookup_value_data}}), 'h1);

        check("m_upd_valid", 64'(bus.m_update_valid), 64'(bus.s_update_valid));
        check("m_upd_index", 64'(bus.m_update_index), 64'(bus.s_update_index));
        check("m_upd_data", bus.m_update_data[63:0], bus.s_update_data[63:0]);
        check("m_upd_ready", 64'(bus.s_update_ready), 64'(bus.m_update_ready));
        check("m_err", 64'(bus.err_unmatched), 64'(exp_err));

        if (rst) begin
          tbl.delete();
          ids.delete();
          last_win = N - 1;
          exp_err  = 1'b0;
        end else begin
          if (bus.s_lookup_value_valid && exp_vr) void'(ids.pop_front());
          exp_err = 1'b0;
          if (bus.s_update_valid && bus.m_update_ready) begin
            found = 1'b0;
            for (int j = 0; j < tbl.size(); j++)
              if (!found && tbl[j] == bus.s_update_index) begin
                tbl.delete(j);
                found = 1'b1;
              end
            exp_err = !found;
          end
          if (win >= 0 && bus.m_lookup_req_ready) begin
            tbl.push_back(bus.s_req_index[win*KW +: KW]);
            ids.push_back(win);
            last_win = win;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] prev_key;
    bus.s_req_index          = '0;
    bus.s_req_valid          = '0;
    bus.m_lookup_req_ready   = 1'b1;
    bus.s_lookup_value_data  = '0;
    bus.s_lookup_value_valid = 1'b0;
    bus.m_value_ready        = '1;
    set_upd(1'b0, '0);
    bus.m_update_ready       = 1'b1;

    rst = 1'b1;
    step();
    step();
    rst      = 1'b0;
    model_on = 1'b1;
    #1;
    check("rst_s_req_ready", 64'(bus.s_req_ready), 'h0);
    check("rst_lookup_valid", 64'(bus.m_lookup_req_valid), 'h0);
    check("rst_value_valid", 64'(bus.m_value_valid), 'h0);
    check("rst_value_ready", 64'(bus.s_lookup_value_ready), 'h0);
    check("rst_err", 64'(bus.err_unmatched), 'h0);

    // Hazard: both requesters on key 0x0007, pointer at 0.
    set_req(0, 16'h0007, 1'b1);
    set_req(1, 16'h0007, 1'b1);
    #1;
    check("hz_grant0", 64'(bus.s_req_ready), 'h1);
    check("hz_index", 64'(bus.m_lookup_req_index), 'h7);
    step();
    bus.s_req_valid[0] = 1'b0;
    #1;
    check("hz_req1_held", 64'(bus.s_req_ready), 'h0);
    step();
    bus.s_lookup_value_valid = 1'b1;
    bus.s_lookup_value_data  = {4{64'h1111_2222_3333_4444}};
    #1;
    check("hz_value0", 64'(bus.m_value_valid), 'h1);
    step();
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b1, 16'h0007);
    #1;
    check("hz_held_at_t", 64'(bus.s_req_ready), 'h0);
    step();
    set_upd(1'b0, '0);
    #1;
    check("hz_grant1_t1", 64'(bus.s_req_ready), 'h2);
    step();
    bus.s_req_valid = '0;
    bus.s_lookup_value_valid = 1'b1;
    #1;
    check("hz_value1", 64'(bus.m_value_valid), 'h2);
    step();
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b1, 16'h0007);
    step();
    set_upd(1'b0, '0);

    // Basic grant and 2-cycle response.
    set_req(0, 16'h0005, 1'b1);
    #1;
    check("basic_grant", 64'(bus.s_req_ready), 'h1);
    check("basic_index", 64'(bus.m_lookup_req_index), 'h5);
    step();
    bus.s_req_valid = '0;
    step();
    bus.s_lookup_value_valid = 1'b1;
    bus.s_lookup_value_data  = {4{64'h0123_4567_89AB_CDEF}};
    #1;
    check("basic_value_valid", 64'(bus.m_value_valid), 'h1);
    check("basic_value_data1", bus.m_value_data[VW +: 64], 64'h0123_4567_89AB_CDEF);
    step();
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b1, 16'h0005);
    step();
    set_upd(1'b0, '0);

    // Fairness: last winner was requester 0, so grants go 1,0,1,0,...
    for (int kk = 0; kk < 8; kk++) begin
      set_req(0, 16'h0100 + 16'(kk), 1'b1);
      set_req(1, 16'h0200 + 16'(kk), 1'b1);
      if (kk > 0) begin
        prev_key = ((kk - 1) % 2 == 0) ? 16'h0200 + 16'(kk - 1) : 16'h0100 + 16'(kk - 1);
        set_upd(1'b1, prev_key);
      end
      bus.s_lookup_value_valid = (kk > 0);
      #1;
      check("rr_grant", 64'(bus.s_req_ready), (kk % 2 == 0) ? 'h2 : 'h1);
      step();
    end
    bus.s_req_valid = '0;
    set_upd(1'b1, 16'h0107);
    bus.s_lookup_value_valid = 1'b1;
    step();
    set_upd(1'b0, '0);
    bus.s_lookup_value_valid = 1'b0;

    // Full table: four keys in flight, fifth key stalls until a retire.
    for (int kk = 1; kk <= 4; kk++) begin
      set_req(0, 16'(kk), 1'b1);
      #1;
      check("full_fill", 64'(bus.s_req_ready), 'h1);
      step();
    end
    set_req(0, 16'h0009, 1'b1);
    #1;
    check("full_stall", 64'(bus.s_req_ready), 'h0);
    step();
    bus.s_lookup_value_valid = 1'b1;
    for (int kk = 0; kk < 4; kk++) begin
      #1;
      check("full_stall_drain", 64'(bus.s_req_ready), 'h0);
      step();
    end
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b1, 16'h0002);
    #1;
    check("full_retire_t", 64'(bus.s_req_ready), 'h0);
    step();
    set_upd(1'b0, '0);
    #1;
    check("full_grant_t1", 64'(bus.s_req_ready), 'h1);
    check("full_index_t1", 64'(bus.m_lookup_req_index), 'h9);
    step();
    bus.s_req_valid = '0;
    bus.s_lookup_value_valid = 1'b1;
    set_upd(1'b1, 16'h0001);
    step();
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b1, 16'h0003);
    step();
    set_upd(1'b1, 16'h0004);
    step();
    set_upd(1'b1, 16'h0009);
    step();
    set_upd(1'b0, '0);

    // Unmatched update on an empty table.
    set_upd(1'b1, 16'h00FF);
    #1;
    check("unm_fwd_valid", 64'(bus.m_update_valid), 'h1);
    check("unm_fwd_index", 64'(bus.m_update_index), 'hFF);
    check("unm_err_before", 64'(bus.err_unmatched), 'h0);
    step();
    set_upd(1'b0, '0);
    #1;
    check("unm_err_pulse", 64'(bus.err_unmatched), 'h1);
    step();
    check("unm_err_gone", 64'(bus.err_unmatched), 'h0);
    bus.m_update_ready = 1'b0;
    set_upd(1'b1, 16'h0055);
    #1;
    check("upd_backpressure", 64'(bus.s_update_ready), 'h0);
    step();
    set_upd(1'b0, '0);
    bus.m_update_ready = 1'b1;
    #1;
    check("upd_no_hs_no_err", 64'(bus.err_unmatched), 'h0);

    // Reset with three lookups outstanding.
    for (int kk = 0; kk < 3; kk++) begin
      set_req(0, 16'h0011 + 16'(kk), 1'b1);
      step();
    end
    bus.s_req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 16'h0011, 1'b1);
    bus.s_lookup_value_valid = 1'b1;
    #1;
    check("mid_rst_value_valid", 64'(bus.m_value_valid), 'h0);
    check("mid_rst_value_ready", 64'(bus.s_lookup_value_ready), 'h0);
    check("mid_rst_regrant", 64'(bus.s_req_ready), 'h1);
    step();
    bus.s_req_valid = '0;
    set_upd(1'b1, 16'h0011);
    step();
    bus.s_lookup_value_valid = 1'b0;
    set_upd(1'b0, '0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
